mag_to_twos_serial: RTL and testbench

- Bit-serial converter from sign-magnitude to two's complement; the inverse of the team's absolute-value block.
- Takes a WIDTH-bit magnitude plus a sign bit over a valid/ready handshake and serially produces the signed two's-complement word, LSB first, using copy-until-first-one-then-invert.
- Flags magnitudes that the signed range cannot represent.
- Sits downstream of arithmetic that works on magnitudes and restores signed values for the datapath.

---
 rtl/mag_to_twos_serial_pkg.sv | 20 ++
 rtl/mag_to_twos_serial_if.sv | 25 ++
 rtl/twos_serial_cell.sv | 12 +
 rtl/mag_to_twos_serial.sv | 111 +++++++++++
 tb/tb_mag_to_twos_serial.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/mag_to_twos_serial_pkg.sv
// Shared types and helpers for the serial sign-magnitude to two's-complement converter.
// Saturation on overflow is enabled by defining MAG_TO_TWOS_SAT_EN.
package mag_to_twos_serial_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    localparam int unsigned DEFAULT_WIDTH = 8;

    // Signed limit of a width, returned as a raw bit pattern (valid for width <= 32).
    function automatic logic [31:0] signed_limit(input int unsigned width, input logic neg);
        logic [31:0] half;
        half = 32'd1 << (width - 1);
        return neg ? half : half - 32'd1;
    endfunction

endpackage

// File: rtl/mag_to_twos_serial_if.sv
// Handshake bus for mag_to_twos_serial: magnitude/sign in, two's-complement word out.
interface mag_to_twos_serial_if
    import mag_to_twos_serial_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] mag;
    logic             sign;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] value;
    logic             overflow;

    modport master (
        output in_valid, mag, sign, out_ready,
        input  in_ready, out_valid, value, overflow
    );

    modport slave (
        input  in_valid, mag, sign, out_ready,
        output in_ready, out_valid, value, overflow
    );
endinterface

// File: rtl/twos_serial_cell.sv
// One bit of serial two's-complement negation: copy bits up to and including the first 1,
// invert the rest when negating. The seen_one state is held by the caller.
module twos_serial_cell (
    input  logic i_b,
    input  logic i_sign,
    input  logic i_seen_one,
    output logic o_out,
    output logic o_seen_one
);
    assign o_out      = i_b ^ (i_sign & i_seen_one);
    assign o_seen_one = i_seen_one | i_b;
endmodule

// File: rtl/mag_to_twos_serial.sv
// Bit-serial sign-magnitude to two's-complement converter, LSB first, WIDTH cycles per word.
// Define MAG_TO_TWOS_SAT_EN to saturate the result on overflow instead of wrapping.
module mag_to_twos_serial
    import mag_to_twos_serial_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input logic                 clk,
    input logic                 rst,
    mag_to_twos_serial_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_e           r_state, w_state_next;
    logic [WIDTH-1:0] r_shift, w_shift_next;
    logic [WIDTH-1:0] r_value, w_value_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic             r_sign, w_sign_next;
    logic             r_seen_one, w_seen_one_next;
    logic             r_overflow, w_overflow_next;
    logic             w_bit;
    logic             w_cell_seen;
    logic             w_last;
    logic             w_mag_ovf;
`ifdef MAG_TO_TWOS_SAT_EN
    logic [WIDTH-1:0] w_sat;
    assign w_sat = WIDTH'(signed_limit(WIDTH, r_sign));
`endif

    twos_serial_cell u_cell (
        .i_b        (r_shift[0]),
        .i_sign     (r_sign),
        .i_seen_one (r_seen_one),
        .o_out      (w_bit),
        .o_seen_one (w_cell_seen)
    );

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    // Negative side reaches one further: -2^(WIDTH-1) is representable.
    assign w_mag_ovf = bus.sign ? (bus.mag[WIDTH-1] & (|bus.mag[WIDTH-2:0]))
                                : bus.mag[WIDTH-1];

    always_comb begin
        w_state_next    = r_state;
        w_shift_next    = r_shift;
        w_value_next    = r_value;
        w_cnt_next      = r_cnt;
        w_sign_next     = r_sign;
        w_seen_one_next = r_seen_one;
        w_overflow_next = r_overflow;
        unique case (r_state)
            StIdle: begin
                if (bus.in_valid) begin
                    w_shift_next    = bus.mag;
                    w_sign_next     = bus.sign;
                    w_seen_one_next = 1'b0;
                    w_cnt_next      = '0;
                    w_overflow_next = w_mag_ovf;
                    w_state_next    = StShift;
                end
            end
            StShift: begin
                w_shift_next    = r_shift >> 1;
                w_value_next    = {w_bit, r_value[WIDTH-1:1]};
                w_seen_one_next = w_cell_seen;
                w_cnt_next      = r_cnt + CNT_W'(1);
                if (w_last) begin
                    w_cnt_next   = '0;
                    w_state_next = StDone;
`ifdef MAG_TO_TWOS_SAT_EN
                    if (r_overflow) begin
                        w_value_next = w_sat;
                    end
`endif
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_shift    <= '0;
            r_value    <= '0;
            r_cnt      <= '0;
            r_sign     <= 1'b0;
            r_seen_one <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_shift    <= w_shift_next;
            r_value    <= w_value_next;
            r_cnt      <= w_cnt_next;
            r_sign     <= w_sign_next;
            r_seen_one <= w_seen_one_next;
            r_overflow <= w_overflow_next;
        end
    end

    assign bus.in_ready  = (r_state == StIdle);
    assign bus.out_valid = (r_state == StDone);
    assign bus.value     = r_value;
    assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_mag_to_twos_serial.sv
// Self-checking bench for mag_to_twos_serial: directed boundary cases, reset abort, and
// randomized transactions against an arithmetic reference model.
module tb_mag_to_twos_serial;
    localparam int unsigned W = 8;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    mag_to_twos_serial_if #(.WIDTH(W)) bus ();

    mag_to_twos_serial #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_ovf(input logic [7:0] m, input logic s);
        int v;
        v = s ? -int'(m) : int'(m);
        return (v > 127) || (v < -128);
    endfunction

    function automatic logic [7:0] ref_value(input logic [7:0] m, input logic s);
        int         v;
        logic [7:0] r;
        v = s ? -int'(m) : int'(m);
        r = 8'(v);
`ifdef MAG_TO_TWOS_SAT_EN
        if (ref_ovf(m, s)) r = s ? 8'h80 : 8'h7F;
`endif
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input string tag, input logic [7:0] m, input logic s, input int gap,
                           input int stall, input logic [7:0] exp_v, input logic exp_o);
        int   n;
        logic was_ready;
        bus.in_valid = 1'b0;
        repeat (gap) tick();
        bus.mag      = m;
        bus.sign     = s;
        bus.in_valid = 1'b1;
        n = 0;
        do begin
            was_ready = bus.in_ready;
            tick();
            n++;
        end while (!was_ready && n < 20);
        check({tag, ".accept"}, 32'(was_ready), 32'd1);
        n = 0;
        while (!bus.out_valid && n < 40) begin
            check({tag, ".busy_in_ready"}, 32'(bus.in_ready), 32'd0);
            // Ignored while busy: garbage on the input bus and random out_ready.
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.mag       = 8'($urandom);
            bus.sign      = 1'($urandom_range(0, 1));
            bus.out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        bus.out_ready = 1'b0;
        check({tag, ".latency"}, 32'(n), 32'(W));
        check({tag, ".value"}, 32'(bus.value), 32'(exp_v));
        check({tag, ".overflow"}, 32'(bus.overflow), 32'(exp_o));
        repeat (stall) begin
            tick();
            check({tag, ".hold_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, ".hold_value"}, 32'(bus.value), 32'(exp_v));
            check({tag, ".hold_in_ready"}, 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check({tag, ".post_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, ".post_in_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] m;
        logic       s;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.mag       = '0;
        bus.sign      = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) tick();
        check("reset.in_ready", 32'(bus.in_ready), 32'd1);
        check("reset.out_valid", 32'(bus.out_valid), 32'd0);
        check("reset.value", 32'(bus.value), 32'd0);
        check("reset.overflow", 32'(bus.overflow), 32'd0);
        // Transfers offered during reset must be dropped.
        bus.in_valid = 1'b1;
        bus.mag      = 8'h05;
        repeat (3) tick();
        bus.in_valid = 1'b0;
        rst          = 1'b0;
        repeat (W + 2) tick();
        check("reset.no_result", 32'(bus.out_valid), 32'd0);

        run_txn("neg_one", 8'h01, 1'b1, 0, 0, 8'hFF, 1'b0);
        run_txn("pos_one_stall", 8'h01, 1'b0, 1, 5, 8'h01, 1'b0);
        run_txn("neg_min", 8'h80, 1'b1, 0, 0, 8'h80, 1'b0);
        run_txn("neg_zero", 8'h00, 1'b1, 2, 1, 8'h00, 1'b0);
`ifdef MAG_TO_TWOS_SAT_EN
        run_txn("pos_ovf", 8'h80, 1'b0, 0, 0, 8'h7F, 1'b1);
        run_txn("neg_ovf", 8'hC8, 1'b1, 0, 2, 8'h80, 1'b1);
`else
        run_txn("pos_ovf", 8'h80, 1'b0, 0, 0, 8'h80, 1'b1);
        run_txn("neg_ovf", 8'hC8, 1'b1, 0, 2, 8'h38, 1'b1);
`endif

        // Abort mid-SHIFT: accept, then reset in the third SHIFT cycle.
        bus.mag      = 8'h55;
        bus.sign     = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("abort.accepted", 32'(bus.in_ready), 32'd0);
        repeat (2) tick();
        rst = 1'b1;
        #1;
        check("abort.value", 32'(bus.value), 32'd0);
        check("abort.overflow", 32'(bus.overflow), 32'd0);
        check("abort.out_valid", 32'(bus.out_valid), 32'd0);
        check("abort.in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        rst = 1'b0;
        repeat (W + 2) tick();
        check("abort.no_result", 32'(bus.out_valid), 32'd0);
        run_txn("after_abort", 8'h2A, 1'b1, 0, 0, 8'hD6, 1'b0);

        for (int i = 0; i < 60; i++) begin
            m = 8'($urandom);
            if (i % 8 == 0) m = {1'b1, 7'($urandom_range(0, 1))};
            s = 1'($urandom_range(0, 1));
            run_txn("random", m, s, $urandom_range(0, 3), $urandom_range(0, 3),
                    ref_value(m, s), ref_ovf(m, s));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
